// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input, in clock cycles.
// Latency: edges recognized SYNC_STAGES cycles after the pin (+FILT_LEN with filter); meas_valid follows the closing rise by 1 cycle.
// Backpressure: one-deep result register; a result arriving while meas_valid=1 and meas_ack=0 is dropped and sets sticky overrun.
//
// Optional glitch filter after the synchronizer: define PWM_CAPTURE_GLITCH_FILTER_EN.
// Counts are in cycles of the conditioned level. Every edge sees the same conditioning
// delay, so that delay does not change the measured values.

module pwm_capture #(
   parameter int unsigned      CNT_W       = 20,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [CNT_W-1:0] TIMEOUT     = {CNT_W{1'b1}},
   parameter int unsigned      FILT_LEN    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_in,
   input  logic             meas_ack,
   output logic [CNT_W-1:0] high_count,
   output logic [CNT_W-1:0] period_count,
   output logic             meas_valid,
   output logic             overrun,
   output logic             timeout,
   output logic             no_signal
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_t;

   // Input conditioning.
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   pwm_s;
   logic                   lvl;
   logic                   lvl_q, lvl_d;
   logic                   rise, fall;

   // Measurement state.
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       cnt_inc;
   logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
   logic                   tmo_hit;
   logic                   publish;

   // Result and status registers.
   logic [CNT_W-1:0]       high_q, high_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;
   logic                   tmo_q, tmo_d;
   logic                   nosig_q, nosig_d;

   // Shift the raw pin into the synchronizer chain; the last stage is the usable level.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
   end

   assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int unsigned FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic            filt_q, filt_d;
   logic [FC_W-1:0] fcnt_q, fcnt_d;

   // Follow pwm_s only once it has disagreed with the filtered level for FILT_LEN cycles in a row.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (pwm_s != filt_q) begin
         if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
            filt_d = pwm_s;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   // Filter state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign lvl = filt_q;
`else
   logic unused_filt_len;
   assign unused_filt_len = (FILT_LEN != 0);
   assign lvl             = pwm_s;
`endif

   // Edge detection against the previous cycle's conditioned level.
   always_comb begin
      lvl_d = lvl;
      rise  = lvl & ~lvl_q;
      fall  = ~lvl & lvl_q;
   end

   // Saturating run counter increment and timeout compare.
   always_comb begin
      cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      tmo_hit = (cnt_q == TIMEOUT);
   end

   // Next-state logic: the rising edge that closes one period opens the next one.
   // Disable wins over timeout, timeout wins over edges.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_inc;
      hi_lat_d = hi_lat_q;
      publish  = 1'b0;
      tmo_d    = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = '0;
            end
            ST_ARM: begin
               if (tmo_hit) begin
                  tmo_d = 1'b1;
                  cnt_d = '0;
               end else if (rise) begin
                  // The edge cycle itself is the first high cycle.
                  state_d = ST_HIGH;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_HIGH: begin
               if (tmo_hit) begin
                  tmo_d   = 1'b1;
                  state_d = ST_ARM;
                  cnt_d   = '0;
               end else if (fall) begin
                  // cnt_q is exactly the number of high cycles since the rise.
                  hi_lat_d = cnt_q;
                  state_d  = ST_LOW;
               end
            end
            ST_LOW: begin
               if (tmo_hit) begin
                  tmo_d   = 1'b1;
                  state_d = ST_ARM;
                  cnt_d   = '0;
               end else if (rise) begin
                  publish = 1'b1;
                  state_d = ST_HIGH;
                  cnt_d   = CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Result handshake: load when empty or being acked this cycle, otherwise drop and flag overrun.
   always_comb begin
      high_d   = high_q;
      period_d = period_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      nosig_d  = nosig_q;
      if (publish) begin
         if (!valid_q || meas_ack) begin
            high_d   = hi_lat_q;
            period_d = cnt_q;
            valid_d  = 1'b1;
            nosig_d  = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (meas_ack) begin
         valid_d = 1'b0;
      end
      if (tmo_d) begin
         nosig_d = 1'b1;
      end
   end

   // State, counter and result registers; reset discards any partial measurement.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= '0;
         lvl_q    <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_lat_q <= '0;
         high_q   <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         tmo_q    <= 1'b0;
         nosig_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         lvl_q    <= lvl_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_lat_q <= hi_lat_d;
         high_q   <= high_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         tmo_q    <= tmo_d;
         nosig_q  <= nosig_d;
      end
   end

   assign high_count   = high_q;
   assign period_count = period_q;
   assign meas_valid   = valid_q;
   assign overrun      = ovr_q;
   assign timeout      = tmo_q;
   assign no_signal    = nosig_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed waveforms, an edge-timestamp reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_pwm_capture;
   localparam int CNT_W = 20;
   localparam int SYNC  = 2;
   localparam int FILT  = 4;
   localparam int TMO   = 50;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT = SYNC + FILT;
`else
   localparam int LAT = SYNC;
`endif

   logic clock = 1'b0;
   logic reset, enable, pwm_in, meas_ack;
   logic [CNT_W-1:0] high_count, period_count;
   logic meas_valid, overrun, timeout, no_signal;

   always #5 clock = ~clock;

   pwm_capture #(
      .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(CNT_W'(TMO)), .FILT_LEN(FILT)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .pwm_in(pwm_in),
      .meas_ack(meas_ack), .high_count(high_count), .period_count(period_count),
      .meas_valid(meas_valid), .overrun(overrun), .timeout(timeout),
      .no_signal(no_signal)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Works on cycle timestamps: high time = fall - rise, period = rise - previous rise,
   // run length = now - reference point (arm start or last rise).
   localparam int M_IDLE = 0, M_ARM = 1, M_INH = 2, M_INL = 3;
   bit   hist[$];
   int   mcyc = 0;
   bit   m_f, m_run_val, m_lprev;
   int   m_run, m_mode, t_ref, hi_len;
   logic [CNT_W-1:0] m_h, m_p;
   bit   m_vld, m_ovr, m_tmo, m_ns;
   bit   cmp_en = 1'b0;

   always @(posedge clock) begin : model
      bit s, l, mr, mfl, pub, fire;
      int per;
      mcyc++;
      if (reset) begin
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
         m_f = 0; m_run_val = 0; m_run = 0; m_lprev = 0;
         m_mode = M_IDLE; t_ref = 0; hi_len = 0;
         m_h = '0; m_p = '0; m_vld = 0; m_ovr = 0; m_tmo = 0; m_ns = 0;
      end else begin
         s = hist.pop_front();
         hist.push_back(pwm_in);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
         l = m_f;
         if (s == m_run_val) m_run++;
         else begin m_run_val = s; m_run = 1; end
         if (m_run >= FILT && s != m_f) m_f = s;
`else
         l = s;
`endif
         mr = l && !m_lprev;
         mfl = !l && m_lprev;
         m_lprev = l;
         pub = 0; fire = 0; per = 0;
         if (!enable) m_mode = M_IDLE;
         else if (m_mode == M_IDLE) begin
            m_mode = M_ARM; t_ref = mcyc + 1;
         end else if (mcyc - t_ref == TMO) begin
            fire = 1; m_mode = M_ARM; t_ref = mcyc + 1;
         end else if (m_mode == M_ARM && mr) begin
            m_mode = M_INH; t_ref = mcyc;
         end else if (m_mode == M_INH && mfl) begin
            hi_len = mcyc - t_ref; m_mode = M_INL;
         end else if (m_mode == M_INL && mr) begin
            pub = 1; per = mcyc - t_ref; t_ref = mcyc; m_mode = M_INH;
         end
         if (pub) begin
            if (!m_vld || meas_ack) begin
               m_h = CNT_W'(hi_len); m_p = CNT_W'(per); m_vld = 1; m_ns = 0;
            end else m_ovr = 1;
         end else if (meas_ack) m_vld = 0;
         m_tmo = fire;
         if (fire) m_ns = 1;
      end
   end

   // Compare all outputs against the model every cycle, away from the clock edge.
   always @(posedge clock) begin
      #2;
      if (cmp_en) begin
         chk("cyc_high_count", 32'(high_count), 32'(m_h));
         chk("cyc_period_count", 32'(period_count), 32'(m_p));
         chk("cyc_meas_valid", 32'(meas_valid), 32'(m_vld));
         chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
         chk("cyc_timeout", 32'(timeout), 32'(m_tmo));
         chk("cyc_no_signal", 32'(no_signal), 32'(m_ns));
      end
   end

   // ---------------- directed stimulus ----------------
   bit   auto_ack = 1'b0;
   logic [CNT_W-1:0] got_h[$];
   logic [CNT_W-1:0] got_p[$];
   int   neg_n = 0, tmo_cnt = 0, tmo_at = 0, first_vld_at = -1, t_drv = 0;

   // Drive pwm_in for n cycles (inputs change on the falling edge); record acked results.
   task automatic cyc(input bit p, input int n, input bit ack = 1'b0);
      for (int i = 0; i < n; i++) begin
         pwm_in = p;
         meas_ack = ack | (auto_ack & meas_valid);
         if (meas_ack && meas_valid) begin
            got_h.push_back(high_count);
            got_p.push_back(period_count);
         end
         @(negedge clock);
         neg_n++;
         if (timeout) begin tmo_cnt++; tmo_at = neg_n; end
         if (meas_valid && first_vld_at < 0) first_vld_at = neg_n;
      end
      meas_ack = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_high"}, 32'(high_count), 0);
      chk({tag, "_period"}, 32'(period_count), 0);
      chk({tag, "_valid"}, 32'(meas_valid), 0);
      chk({tag, "_overrun"}, 32'(overrun), 0);
      chk({tag, "_timeout"}, 32'(timeout), 0);
      chk({tag, "_no_signal"}, 32'(no_signal), 0);
   endtask

   task automatic do_reset();
      enable = 1'b0;
      auto_ack = 1'b0;
      reset = 1'b1;
      cyc(1'b0, 2);
      chk_zero("rst");
      reset = 1'b0;
      cmp_en = 1'b1;
      got_h.delete();
      got_p.delete();
      tmo_cnt = 0;
      first_vld_at = -1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; pwm_in = 1'b0; meas_ack = 1'b0;
      @(negedge clock);

      // Basic: 4 high / 6 low, acked results, three identical measurements.
      do_reset();
      enable = 1'b1; auto_ack = 1'b1;
      cyc(0, 3);
      cyc(1, 4); cyc(0, 6);
      t_drv = neg_n;
      cyc(1, 4); cyc(0, 6);
      cyc(1, 4); cyc(0, 6);
      cyc(1, 4); cyc(0, 8);
      enable = 1'b0; cyc(0, 2);
      chk("basic_count", 32'(got_h.size()), 3);
      chk("basic_h0", 32'(got_h[0]), 4);
      chk("basic_p0", 32'(got_p[0]), 10);
      chk("basic_h1", 32'(got_h[1]), 4);
      chk("basic_p1", 32'(got_p[1]), 10);
      chk("basic_h2", 32'(got_h[2]), 4);
      chk("basic_p2", 32'(got_p[2]), 10);
      // pin sampled on the next edge, SYNC (+FILT) to recognize, one more to register
      chk("basic_latency", 32'(first_vld_at - t_drv), 32'(LAT + 1));

      // Overrun: never ack; second result (3/8) must be dropped.
      do_reset();
      enable = 1'b1;
      cyc(0, 3);
      cyc(1, 4); cyc(0, 6);
      cyc(1, 3); cyc(0, 5);
      cyc(1, 4); cyc(0, 6);
      chk("ovr_flag", 32'(overrun), 1);
      chk("ovr_valid", 32'(meas_valid), 1);
      chk("ovr_high", 32'(high_count), 4);
      chk("ovr_period", 32'(period_count), 10);

      // Ack in the publish cycle: new result 2/7 loads, no overrun.
      do_reset();
      enable = 1'b1;
      cyc(0, 3);
      cyc(1, 4); cyc(0, 6);
      cyc(1, 2); cyc(0, 5);
      cyc(1, LAT); cyc(1, 1, 1'b1); cyc(1, 1); cyc(0, 4);
      chk("simack_valid", 32'(meas_valid), 1);
      chk("simack_high", 32'(high_count), 2);
      chk("simack_period", 32'(period_count), 7);
      chk("simack_overrun", 32'(overrun), 0);

      // Timeout: hold high; counter reads TMO after TMO high cycles, pulse is registered.
      do_reset();
      enable = 1'b1; auto_ack = 1'b1;
      cyc(0, 3);
      t_drv = neg_n;
      cyc(1, 60);
      chk("tmo_pulses", 32'(tmo_cnt), 1);
      chk("tmo_when", 32'(tmo_at - t_drv), 32'(LAT + TMO + 1));
      chk("tmo_no_signal", 32'(no_signal), 1);
      chk("tmo_no_result", 32'(meas_valid), 0);
      cyc(0, 5); cyc(1, 5); cyc(0, 5); cyc(1, 5); cyc(0, 4);
      chk("tmo_resume_count", 32'(got_h.size()), 1);
      chk("tmo_resume_h", 32'(got_h[0]), 5);
      chk("tmo_resume_p", 32'(got_p[0]), 10);
      chk("tmo_resume_ns", 32'(no_signal), 0);
      chk("tmo_pulses_after", 32'(tmo_cnt), 1);
      enable = 1'b0; cyc(0, 2);

      // Disable mid-HIGH, then a clean period, then reset mid-LOW.
      do_reset();
      enable = 1'b1; auto_ack = 1'b1;
      cyc(0, 3);
      cyc(1, LAT + 2);
      enable = 1'b0;
      cyc(1, 2); cyc(0, 2);
      enable = 1'b1;
      cyc(0, 2);
      chk("dis_valid", 32'(meas_valid), 0);
      chk("dis_count", 32'(got_h.size()), 0);
      cyc(1, 4); cyc(0, 6); cyc(1, 4); cyc(0, LAT + 4);
      chk("dis_clean_count", 32'(got_h.size()), 1);
      chk("dis_clean_h", 32'(got_h[0]), 4);
      chk("dis_clean_p", 32'(got_p[0]), 10);
      reset = 1'b1;
      cyc(0, 1);
      chk_zero("rstmid");
      reset = 1'b0;
      enable = 1'b0;
      cyc(0, 2);

      // Glitch: 2-cycle low dip inside a 20-cycle high phase.
      do_reset();
      enable = 1'b1; auto_ack = 1'b1;
      cyc(0, 3);
      cyc(1, 8); cyc(0, 2); cyc(1, 10); cyc(0, 10);
      cyc(1, 4); cyc(0, LAT + 4);
      enable = 1'b0; cyc(0, 2);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      chk("glitch_count", 32'(got_h.size()), 1);
      chk("glitch_h", 32'(got_h[0]), 20);
      chk("glitch_p", 32'(got_p[0]), 30);
`else
      chk("glitch_count", 32'(got_h.size()), 2);
      chk("glitch_h0", 32'(got_h[0]), 8);
      chk("glitch_p0", 32'(got_p[0]), 10);
      chk("glitch_h1", 32'(got_h[1]), 10);
      chk("glitch_p1", 32'(got_p[1]), 20);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
